// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, class enum and classify helper for the FP pipeline
// Purpose: default binary32 field widths, bias/limit constants, canonical qNaN,
//          out_flags bit positions and operand classification.
// Ports:   none (package).
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_DATA_W = 1 + FP_EXP_W + FP_MAN_W;

  localparam int EXP_BIAS = 2**(FP_EXP_W-1) - 1;
  localparam int EXP_MAX  = 2**FP_EXP_W - 1;

  localparam logic [FP_DATA_W-1:0] QNAN =
    {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};

  // out_flags = {invalid, overflow, underflow, inexact}
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  // Width-independent: the caller supplies the field tests. A zero exponent is
  // always zero because denormals are flushed.
  function automatic fp_class_e fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero)
      return CLS_ZERO;
    else if (exp_ones)
      return frac_zero ? CLS_INF : CLS_NAN;
    else
      return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter
// Purpose: count leading zeros of data, MSB first; all-zero input gives W.
// Ports:   data  in  W   value to scan
//          count out CW  number of leading zeros
module fp_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data[i])
        count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - 3-stage pipelined FP adder/subtractor with valid/ready
// Purpose: S1 unpack/specials/swap/align, S2 add or subtract, S3 normalise,
//          round-to-nearest-even and pack. Denormals flushed to zero.
// Ports:   clk, reset (sync, active-high)
//          in_valid/in_ready, in_a, in_b, in_sub (1: A-B), in_tag
//          out_valid/out_ready, out_data, out_tag,
//          out_flags {invalid, overflow, underflow, inexact}
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic                     in_sub,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               out_flags
);

  localparam int DW  = 1 + EXP_W + MAN_W;
  localparam int MW4 = MAN_W + 4;            // hidden + frac + G,R,S
  localparam int EW2 = EXP_W + 2;            // signed exponent, no wrap
  localparam int LZW = $clog2(MW4 + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [DW-1:0] QNAN_D = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EW2-1:0] E_TOP  = EW2'(2**EXP_W - 1);
  localparam logic signed [EW2-1:0] E_ZERO = '0;

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: unpack, specials, swap, align ----------------
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_f, b_f;
  fp_class_e        a_c, b_c;

  assign a_s = in_a[DW-1];
  assign a_e = in_a[DW-2:MAN_W];
  assign a_f = in_a[MAN_W-1:0];
  assign b_s = in_b[DW-1] ^ in_sub;
  assign b_e = in_b[DW-2:MAN_W];
  assign b_f = in_b[MAN_W-1:0];
  assign a_c = fp_classify(a_e == '0, a_e == EXP_ONES, a_f == '0);
  assign b_c = fp_classify(b_e == '0, b_e == EXP_ONES, b_f == '0);

  logic             a_big, big_s;
  logic [EXP_W-1:0] big_e, small_e, diff, sh;
  logic [MAN_W-1:0] big_f, small_f;
  logic [2*MW4-1:0] wide;
  logic [MW4-1:0]   small_al;

  assign a_big   = {a_e, a_f} >= {b_e, b_f};
  assign big_s   = a_big ? a_s : b_s;
  assign big_e   = a_big ? a_e : b_e;
  assign big_f   = a_big ? a_f : b_f;
  assign small_e = a_big ? b_e : a_e;
  assign small_f = a_big ? b_f : a_f;
  assign diff    = big_e - small_e;
  // Clamp so every bit of the small mantissa lands in the lower (lost) half.
  assign sh      = (diff > EXP_W'(MW4)) ? EXP_W'(MW4) : diff;
  assign wide    = {1'b1, small_f, 3'b000, {MW4{1'b0}}} >> sh;
  assign small_al = {wide[2*MW4-1:MW4+1], wide[MW4] | (|wide[MW4-1:0])};

  logic          spec, spec_inv;
  logic [DW-1:0] spec_d;

  always_comb begin
    spec     = 1'b1;
    spec_inv = 1'b0;
    spec_d   = '0;
    if (a_c == CLS_NAN || b_c == CLS_NAN ||
        (a_c == CLS_INF && b_c == CLS_INF && a_s != b_s)) begin
      spec_d   = QNAN_D;
      spec_inv = 1'b1;
    end else if (a_c == CLS_INF)
      spec_d = {a_s, EXP_ONES, {MAN_W{1'b0}}};
    else if (b_c == CLS_INF)
      spec_d = {b_s, EXP_ONES, {MAN_W{1'b0}}};
    else if (a_c == CLS_ZERO && b_c == CLS_ZERO)
      spec_d = {a_s & b_s, {(DW-1){1'b0}}};
    else if (a_c == CLS_ZERO)
      spec_d = {b_s, b_e, b_f};
    else if (b_c == CLS_ZERO)
      spec_d = {a_s, a_e, a_f};
    else
      spec = 1'b0;
  end

  logic             s1_valid, s1_spec, s1_spec_inv, s1_sign, s1_eff_sub;
  logic [TAG_W-1:0] s1_tag;
  logic [DW-1:0]    s1_spec_d;
  logic [EXP_W-1:0] s1_exp;
  logic [MW4-1:0]   s1_big, s1_small;

  // ---------------- S2: add / subtract ----------------
  logic             s2_valid, s2_spec, s2_spec_inv, s2_sign;
  logic [TAG_W-1:0] s2_tag;
  logic [DW-1:0]    s2_spec_d;
  logic [EXP_W-1:0] s2_exp;
  logic [MW4:0]     s2_sum;

  // ---------------- S3: normalise, round, pack ----------------
  logic [LZW-1:0]          lz;
  logic [MW4-1:0]          norm;
  logic signed [EW2-1:0]   e;
  logic                    rnd_up;
  logic [MAN_W+1:0]        man;
  logic [MAN_W-1:0]        frac;
  logic [DW-1:0]           res;
  logic [3:0]              fl;

  fp_lzc #(.W(MW4), .CW(LZW)) u_lzc (
    .data  (s2_sum[MW4-1:0]),
    .count (lz)
  );

  always_comb begin
    res  = '0;
    fl   = '0;
    frac = '0;
    if (s2_sum[MW4]) begin
      norm = {s2_sum[MW4:2], s2_sum[1] | s2_sum[0]};
      e    = $signed({2'b00, s2_exp}) + EW2'(1);
    end else begin
      norm = s2_sum[MW4-1:0] << lz;
      e    = $signed({2'b00, s2_exp}) - EW2'(lz);
    end
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    man    = {1'b0, norm[MW4-1:3]} + (MAN_W+2)'(rnd_up);
    if (man[MAN_W+1])
      e = e + EW2'(1);            // rounded up to 2.0: fraction is all zeros
    else
      frac = man[MAN_W-1:0];

    if (s2_spec) begin
      res              = s2_spec_d;
      fl[FLAG_INVALID] = s2_spec_inv;
    end else if (s2_sum == '0) begin
      res = '0;                   // exact cancellation is +0
    end else if (e >= E_TOP) begin
      res                = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      fl[FLAG_OVERFLOW]  = 1'b1;
      fl[FLAG_INEXACT]   = 1'b1;
    end else if (e <= E_ZERO) begin
      res                = {s2_sign, {(DW-1){1'b0}}};
      fl[FLAG_UNDERFLOW] = 1'b1;
      fl[FLAG_INEXACT]   = 1'b1;
    end else begin
      res              = {s2_sign, e[EXP_W-1:0], frac};
      fl[FLAG_INEXACT] = |norm[2:0];
    end
  end

  // All stages move together; a stalled output freezes the whole pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (adv) begin
      s1_valid    <= in_valid;
      s1_tag      <= in_tag;
      s1_spec     <= spec;
      s1_spec_inv <= spec_inv;
      s1_spec_d   <= spec_d;
      s1_sign     <= big_s;
      s1_eff_sub  <= a_s ^ b_s;
      s1_exp      <= big_e;
      s1_big      <= {1'b1, big_f, 3'b000};
      s1_small    <= small_al;

      s2_valid    <= s1_valid;
      s2_tag      <= s1_tag;
      s2_spec     <= s1_spec;
      s2_spec_inv <= s1_spec_inv;
      s2_spec_d   <= s1_spec_d;
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= s1_eff_sub ? {1'b0, s1_big} - {1'b0, s1_small}
                                : {1'b0, s1_big} + {1'b0, s1_small};

      out_valid   <= s2_valid;
      out_tag     <= s2_tag;
      out_data    <= res;
      out_flags   <= fl;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb/tb_fp_addsub_pipe.sv - self-checking scoreboard bench for fp_addsub_pipe
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  flags;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   outs_seen = 0;

  fp_addsub_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted output is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      outs_seen++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output data=%h tag=%0d required=no output", out_data, out_tag);
      end else begin
        mon_e = sb_q.pop_front();
        if ({out_data, out_flags, out_tag} !== mon_e) begin
          failures++;
          $display("FAIL result data=%h flags=%b tag=%0d required data=%h flags=%b tag=%0d",
                   out_data, out_flags, out_tag, mon_e.data, mon_e.flags, mon_e.tag);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair and hold it until accepted (bounded).
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [3:0] tag, input logic [31:0] ed, input logic [3:0] ef);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_tag   = tag;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (in_ready) begin
        sb_q.push_back({ed, ef, tag});
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout tag=%0d in_ready=%b required=1", tag, in_ready);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({out_valid, out_data, out_tag, out_flags} !== 41'd0) begin
      failures++;
      $display("FAIL reset_state valid=%b data=%h tag=%0d flags=%b required all zero",
               out_valid, out_data, out_tag, out_flags);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 32'h3F800000;
    in_b      = 32'h40000000;
    in_sub    = 1'b0;
    in_tag    = 4'd1;
    sb_q.push_back({32'h40400000, 4'b0000, 4'd1});
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (out_valid !== (c == 3)) begin
        failures++;
        $display("FAIL latency_cycle%0d out_valid=%b required=%b", c, out_valid, c == 3);
      end
      if (c < 3) tick();
    end
    checks++;
    if (out_data !== 32'h40400000) begin
      failures++;
      $display("FAIL latency_data out_data=%h required=40400000", out_data);
    end
    repeat (2) tick();
  endtask

  task automatic test_vectors();
    out_ready = 1'b1;
    send(32'h3F800000, 32'h3F800000, 1'b1, 4'd0,  32'h00000000, 4'b0000);
    send(32'h3F800000, 32'h33800000, 1'b0, 4'd1,  32'h3F800000, 4'b0001);
    send(32'h3F800001, 32'h33800000, 1'b0, 4'd2,  32'h3F800002, 4'b0001);
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd3,  32'h7F800000, 4'b0101);
    send(32'h7F800000, 32'hFF800000, 1'b0, 4'd4,  32'h7FC00000, 4'b1000);
    send(32'h7F800000, 32'h7F800000, 1'b1, 4'd5,  32'h7FC00000, 4'b1000);
    send(32'h7FC00001, 32'h3F800000, 1'b0, 4'd6,  32'h7FC00000, 4'b1000);
    send(32'h7F800000, 32'h3F800000, 1'b1, 4'd7,  32'h7F800000, 4'b0000);
    send(32'hFF800000, 32'h3F800000, 1'b0, 4'd8,  32'hFF800000, 4'b0000);
    send(32'h00000000, 32'h3F800000, 1'b1, 4'd9,  32'hBF800000, 4'b0000);
    send(32'h80000000, 32'h00000000, 1'b1, 4'd10, 32'h80000000, 4'b0000);
    send(32'h00800001, 32'h00800000, 1'b1, 4'd11, 32'h00000000, 4'b0011);
    send(32'h3F800000, 32'h00800000, 1'b0, 4'd12, 32'h3F800000, 4'b0001);
    send(32'h3FFFFFFF, 32'h3F800000, 1'b0, 4'd13, 32'h40400000, 4'b0001);
    send(32'h3FFFFFFF, 32'h33800000, 1'b0, 4'd14, 32'h40000000, 4'b0001);
    send(32'h40400000, 32'h3F800000, 1'b1, 4'd15, 32'h40000000, 4'b0000);
    in_valid = 1'b0;
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) tick();
    checks++;
    if (sb_q.size() !== 0) begin
      failures++;
      $display("FAIL vectors_drain pending=%0d required=0", sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int          base;
    int          w;
    logic [31:0] held;
    base      = outs_seen;
    out_ready = 1'b0;
    fork
      begin
        send(32'h3F800000, 32'h3F800000, 1'b0, 4'd0, 32'h40000000, 4'b0000);
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd1, 32'h40400000, 4'b0000);
        send(32'h40000000, 32'h40000000, 1'b0, 4'd2, 32'h40800000, 4'b0000);
        send(32'h40400000, 32'h3F800000, 1'b0, 4'd3, 32'h40800000, 4'b0000);
        send(32'h40800000, 32'h3F800000, 1'b1, 4'd4, 32'h40400000, 4'b0000);
        send(32'h40000000, 32'h40400000, 1'b1, 4'd5, 32'hBF800000, 4'b0000);
        in_valid = 1'b0;
      end
      begin
        w = 0;
        while (!out_valid && w < 20) begin
          tick();
          w++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("FAIL stall_first_valid out_valid=%b required=1", out_valid);
        end
        held = out_data;
        repeat (5) begin
          tick();
          checks++;
          if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold valid=%b data=%h in_ready=%b required valid=1 data=%h in_ready=0",
                     out_valid, out_data, in_ready, held);
          end
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
    checks++;
    if (sb_q.size() !== 0 || outs_seen - base !== 6) begin
      failures++;
      $display("FAIL stall_count emitted=%0d pending=%0d required emitted=6 pending=0",
               outs_seen - base, sb_q.size());
    end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1;
    send(32'h3F800000, 32'h40000000, 1'b0, 4'd7, 32'h40400000, 4'b0000);
    send(32'h40000000, 32'h40000000, 1'b0, 4'd8, 32'h40800000, 4'b0000);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_reset out_valid=%b required=0", out_valid);
    end
    reset = 1'b0;
    sb_q.delete();
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_stale cycle=%0d out_valid=%b required=0", c, out_valid);
      end
    end
    in_valid = 1'b1;
    in_a     = 32'h40400000;
    in_b     = 32'h3F800000;
    in_sub   = 1'b0;
    in_tag   = 4'd9;
    sb_q.push_back({32'h40800000, 4'b0000, 4'd9});
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (out_valid !== (c == 3)) begin
        failures++;
        $display("FAIL flush_latency_cycle%0d out_valid=%b required=%b", c, out_valid, c == 3);
      end
      if (c < 3) tick();
    end
    repeat (3) tick();
    checks++;
    if (sb_q.size() !== 0) begin
      failures++;
      $display("FAIL flush_drain pending=%0d required=0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
